// File: rtl/crack_sequencer.sv
// Host-side sequencer for the ntcrackfpga core: loads target hashes, starts the search,
// and streams the recovered password out through a valid/ready port.
module crack_sequencer #(
    parameter int unsigned HASH_COUNT     = 128,
    parameter int unsigned HASH_BYTES     = 16,
    parameter int unsigned MAX_PW_LEN     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_start,
    input  logic       host_valid,
    input  logic [7:0] host_byte,
    output logic       host_ready,
    output logic [7:0] new_hash_byte,
    output logic       store_hash_byte,
    output logic       go,
    input  logic       your_turn,
    input  logic       match_found,
    input  logic [7:0] password_byte,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       timeout_err
);

    localparam int unsigned TotalBytes = HASH_COUNT * HASH_BYTES;
    localparam int unsigned ByteW      = (TotalBytes > 1) ? $clog2(TotalBytes) : 1;
    localparam int unsigned PwW        = $clog2(MAX_PW_LEN + 1);

    localparam logic [ByteW-1:0] LastByte = ByteW'(TotalBytes - 1);
    localparam logic [PwW-1:0]   PwMax    = PwW'(MAX_PW_LEN);
    localparam logic [15:0]      TmoLimit = 16'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        StIdle,
        StLoadWait,
        StLoadReq,
        StLoadRel,
        StGoReq,
        StGoRel,
        StRdReq,
        StRdRel,
        StEmit,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [ByteW-1:0] byte_cnt_q, byte_cnt_d, byte_inc;
    logic [PwW-1:0]   pw_cnt_q, pw_cnt_d, pw_inc;
    logic [15:0]      tmo_q, tmo_d, tmo_inc;
    logic             found_q, found_d;
    logic             tmo_err_q, tmo_err_d;
    logic [7:0]       nhb_q, nhb_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             wait_tick;
    logic             tmo_expired;

    logic host_ready_q, store_q, go_q, out_valid_q, busy_q, done_q;

    assign byte_inc    = byte_cnt_q + ByteW'(1);
    assign pw_inc      = pw_cnt_q + PwW'(1);
    assign tmo_inc     = tmo_q + 16'd1;
    assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_inc == TmoLimit);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pw_cnt_d   = pw_cnt_q;
        tmo_d      = tmo_q;
        found_d    = found_q;
        tmo_err_d  = tmo_err_q;
        nhb_d      = nhb_q;
        out_byte_d = out_byte_q;
        wait_tick  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (host_start) begin
                    byte_cnt_d = '0;
                    pw_cnt_d   = '0;
                    found_d    = 1'b0;
                    tmo_err_d  = 1'b0;
                    state_d    = StLoadWait;
                end
            end
            StLoadWait: begin
                if (host_valid) begin
                    nhb_d   = host_byte;
                    state_d = StLoadReq;
                end
            end
            StLoadReq: begin
                if (your_turn) state_d = StLoadRel;
                else           wait_tick = 1'b1;
            end
            StLoadRel: begin
                if (!your_turn) begin
                    if (byte_cnt_q == LastByte) begin
                        state_d = StGoReq;
                    end else begin
                        byte_cnt_d = byte_inc;
                        state_d    = StLoadWait;
                    end
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StGoReq: begin
                if (your_turn) begin
                    found_d = match_found;
                    state_d = StGoRel;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StGoRel: begin
                if (!your_turn) begin
                    if (found_q) begin
                        nhb_d   = 8'h00;
                        state_d = StRdReq;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StRdReq: begin
                if (your_turn) begin
                    out_byte_d = password_byte;
                    state_d    = StRdRel;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StRdRel: begin
                if (!your_turn) begin
                    // A zero byte terminates the password and is never emitted.
                    state_d = (out_byte_q == 8'h00) ? StDone : StEmit;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    pw_cnt_d = pw_inc;
                    if (pw_inc == PwMax) begin
                        state_d = StDone;
                    end else begin
                        nhb_d   = 8'h00;
                        state_d = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wait_tick) begin
            if (tmo_expired) begin
                tmo_err_d = 1'b1;
                found_d   = 1'b0;
                state_d   = StDone;
            end else begin
                tmo_d = tmo_inc;
            end
        end

        if (state_d != state_q) tmo_d = '0;
    end

    // Handshake and status outputs are registered from the next state so they change
    // exactly on the edge the state does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            byte_cnt_q   <= '0;
            pw_cnt_q     <= '0;
            tmo_q        <= '0;
            found_q      <= 1'b0;
            tmo_err_q    <= 1'b0;
            nhb_q        <= 8'h00;
            out_byte_q   <= 8'h00;
            host_ready_q <= 1'b0;
            store_q      <= 1'b0;
            go_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            pw_cnt_q     <= pw_cnt_d;
            tmo_q        <= tmo_d;
            found_q      <= found_d;
            tmo_err_q    <= tmo_err_d;
            nhb_q        <= nhb_d;
            out_byte_q   <= out_byte_d;
            host_ready_q <= (state_d == StLoadWait);
            store_q      <= (state_d == StLoadReq) || (state_d == StRdReq);
            go_q         <= (state_d == StGoReq);
            out_valid_q  <= (state_d == StEmit);
            busy_q       <= (state_d != StIdle) && (state_d != StDone);
            done_q       <= (state_d == StDone);
        end
    end

    assign host_ready      = host_ready_q;
    assign new_hash_byte   = nhb_q;
    assign store_hash_byte = store_q;
    assign go              = go_q;
    assign out_valid       = out_valid_q;
    assign out_byte        = out_byte_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign found           = found_q;
    assign timeout_err     = tmo_err_q;

endmodule

// File: tb/tb_crack_sequencer.sv
// Directed bench for crack_sequencer: a 4-phase core model, host byte source and
// password consumer, with hand-derived expectations for each job.
module tb_crack_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, host_start, host_valid, host_ready;
    logic [7:0] host_byte, new_hash_byte, password_byte, out_byte;
    logic       store_hash_byte, go, your_turn, match_found;
    logic       out_valid, out_ready, busy, done, found, timeout_err;

    crack_sequencer #(
        .HASH_COUNT    (128),
        .HASH_BYTES    (16),
        .MAX_PW_LEN    (20),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_start     (host_start),
        .host_valid     (host_valid),
        .host_byte      (host_byte),
        .host_ready     (host_ready),
        .new_hash_byte  (new_hash_byte),
        .store_hash_byte(store_hash_byte),
        .go             (go),
        .your_turn      (your_turn),
        .match_found    (match_found),
        .password_byte  (password_byte),
        .out_valid      (out_valid),
        .out_byte       (out_byte),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .timeout_err    (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hbyte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    logic [23:0] outs;
    assign outs = {host_ready, store_hash_byte, go, out_valid, busy, done, found, timeout_err,
                   new_hash_byte, out_byte};

    // Core, host-source and consumer models
    logic       model_clr;
    int         hold_at;
    logic       hold_go;
    logic       rd_phase;
    logic       store_prev, go_prev;
    logic       ack_block;
    logic [7:0] pw_mem   [32];
    logic [7:0] emit_mem [32];
    int host_idx, ld_cnt, ld_err, rd_acks, rd_err, store_rises, go_rises, store_at_go, emit_n;

    assign host_byte = hbyte(host_idx);
    assign ack_block = (go && hold_go) || (store_hash_byte && !rd_phase && ld_cnt == hold_at);

    always @(posedge clk) begin
        if (model_clr) begin
            host_idx <= 0; ld_cnt <= 0; ld_err <= 0; rd_acks <= 0; rd_err <= 0;
            store_rises <= 0; go_rises <= 0; store_at_go <= 0; emit_n <= 0;
            store_prev <= 1'b0; go_prev <= 1'b0; your_turn <= 1'b0; rd_phase <= 1'b0;
            password_byte <= 8'h00;
        end else begin
            store_prev <= store_hash_byte;
            go_prev    <= go;
            if (host_valid && host_ready) host_idx <= host_idx + 1;
            if (store_hash_byte && !store_prev) store_rises <= store_rises + 1;
            if (go && !go_prev) begin
                go_rises    <= go_rises + 1;
                store_at_go <= store_rises;
            end
            if (out_valid && out_ready) begin
                emit_mem[emit_n[4:0]] <= out_byte;
                emit_n <= emit_n + 1;
            end
            if (!store_hash_byte && !go) begin
                your_turn <= 1'b0;
            end else if (!your_turn && !ack_block) begin
                your_turn <= 1'b1;
                if (go) begin
                    rd_phase <= 1'b1;
                end else if (rd_phase) begin
                    password_byte <= pw_mem[rd_acks[4:0]];
                    rd_acks <= rd_acks + 1;
                    if (new_hash_byte != 8'h00) rd_err <= rd_err + 1;
                end else begin
                    if (new_hash_byte != hbyte(ld_cnt)) ld_err <= ld_err + 1;
                    ld_cnt <= ld_cnt + 1;
                end
            end
        end
    end

    task automatic clr_model();
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    task automatic start_job();
        host_start = 1'b1;
        @(negedge clk);
        host_start = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        reset     = 1'b1;
        model_clr = 1'b1;
        @(negedge clk);
        check_eq(tag, 32'(outs), 0);
        reset     = 1'b0;
        model_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_pw(input string s);
        for (int i = 0; i < 32; i++) pw_mem[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic wait_done(input int budget, output int nb);
        nb = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && !done) nb++;
        end
        check_eq("done", 32'(done), 1);
    endtask

    task automatic wait_out_valid(input int budget, output int nb);
        nb = 0;
        for (int i = 0; i < budget && !out_valid; i++) begin
            @(negedge clk);
            if (!busy) nb++;
        end
        check_eq("out_valid_seen", 32'(out_valid), 1);
    endtask

    initial begin
        int nb;
        int chg;

        reset = 1'b1; host_start = 1'b1; host_valid = 1'b0; out_ready = 1'b1;
        match_found = 1'b0; hold_at = -1; hold_go = 1'b0; model_clr = 1'b1;
        set_pw("");
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_outs", 32'(outs), 0);
        reset = 1'b0; host_start = 1'b0; model_clr = 1'b0;
        @(negedge clk);
        check_eq("rst_beats_start", 32'({busy, host_ready}), 0);

        // Reset in LOAD_WAIT, LOAD_REQ (with your_turn high) and LOAD_REL
        start_job();
        check_eq("ldwait_ready", 32'({busy, host_ready}), 32'h3);
        pulse_reset("rst_ldwait");
        host_valid = 1'b1;
        start_job();
        for (int i = 0; i < 20 && !(store_hash_byte && your_turn); i++) @(negedge clk);
        check_eq("ldreq_seen", 32'({store_hash_byte, your_turn}), 32'h3);
        pulse_reset("rst_ldreq");
        start_job();
        for (int i = 0; i < 20 && !(!store_hash_byte && your_turn); i++) @(negedge clk);
        check_eq("ldrel_seen", 32'({busy, store_hash_byte, your_turn}), 32'h5);
        pulse_reset("rst_ldrel");

        // Full load, match, password "abc", consumer stalls on the first byte
        set_pw("abc");
        match_found = 1'b1;
        out_ready   = 1'b0;
        start_job();
        wait_out_valid(20000, nb);
        check_eq("busy_during_job", nb, 0);
        check_eq("load_rises", store_at_go, 2048);
        check_eq("load_acks", ld_cnt, 2048);
        check_eq("load_data_err", ld_err, 0);
        check_eq("go_pulses", go_rises, 1);
        check_eq("first_byte", 32'(out_byte), 32'h61);
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_byte != 8'h61 || !out_valid) chg++;
        end
        check_eq("stall_hold", chg, 0);
        out_ready = 1'b1;
        wait_done(200, nb);
        check_eq("abc_count", emit_n, 3);
        check_eq("abc_0", 32'(emit_mem[0]), 32'h61);
        check_eq("abc_1", 32'(emit_mem[1]), 32'h62);
        check_eq("abc_2", 32'(emit_mem[2]), 32'h63);
        check_eq("abc_flags", 32'({busy, found, timeout_err}), 32'h2);
        check_eq("abc_reads", rd_acks, 4);
        check_eq("rd_data_zero", rd_err, 0);

        // 25-byte password: only 20 bytes emitted, no further reads
        clr_model();
        for (int i = 0; i < 32; i++) pw_mem[i] = (i < 25) ? 8'(8'h41 + i) : 8'h00;
        start_job();
        wait_done(20000, nb);
        check_eq("long_count", emit_n, 20);
        check_eq("long_last", 32'(emit_mem[19]), 32'h54);
        check_eq("long_reads", rd_acks, 20);
        check_eq("long_found", 32'(found), 1);
        pulse_reset("rst_done");

        // Core never acks the 3rd load byte
        clr_model();
        hold_at = 2;
        start_job();
        wait_done(200, nb);
        check_eq("tmo_flags", 32'({timeout_err, found, store_hash_byte, busy}), 32'h8);
        check_eq("tmo_acks", ld_cnt, 2);

        // Clean rerun from DONE, no match
        hold_at = -1;
        match_found = 1'b0;
        clr_model();
        start_job();
        wait_done(20000, nb);
        check_eq("nomatch_busy", nb, 0);
        check_eq("nomatch_flags", 32'({timeout_err, found}), 0);
        check_eq("nomatch_load", ld_cnt, 2048);
        check_eq("nomatch_data_err", ld_err, 0);
        check_eq("nomatch_go", go_rises, 1);
        check_eq("nomatch_reads", rd_acks, 0);
        check_eq("nomatch_emit", emit_n, 0);

        // Reset while GO_REQ waits on the core
        clr_model();
        hold_go = 1'b1;
        start_job();
        for (int i = 0; i < 20000 && !go; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("goreq_seen", 32'({go, busy}), 32'h3);
        pulse_reset("rst_goreq");
        hold_go = 1'b0;

        // Reset while EMIT waits on the consumer
        clr_model();
        set_pw("ab");
        match_found = 1'b1;
        out_ready   = 1'b0;
        start_job();
        wait_out_valid(20000, nb);
        pulse_reset("rst_emit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
